trng_seq_ctrl: RTL and testbench

- Sequencer between the entropy unit / de-bias pair and any byte consumer.
- Drives the ring-oscillator chain enable and waits a programmable warm-up.
- Packs de-biased valid bits into DATA_W-bit words and offers them on a valid/ready handshake.
- Runs a repetition-count health test; a failure stops generation until restarted.

---
 rtl/trng_pkg.sv | 20 ++
 rtl/trng_rep_test.sv | 40 ++++
 rtl/trng_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_trng_seq_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared state encoding and defaults for the TRNG sequencer.
package trng_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WARMUP  = 3'd1;
  localparam logic [2:0] ST_COLLECT = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_FAIL    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    WARMUP  = ST_WARMUP,
    COLLECT = ST_COLLECT,
    HOLD    = ST_HOLD,
    FAIL    = ST_FAIL
  } state_t;

  localparam int REP_LIMIT_DEF = 16;

endpackage

// File: rtl/trng_rep_test.sv
// Repetition-count health test: flags a run of REP_LIMIT identical valid bits.
module trng_rep_test
  import trng_pkg::*;
#(
  parameter int REP_LIMIT = REP_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic in_bit,
  input  logic valid,
  output logic fail
);

  logic       last;
  logic [7:0] cnt;
  logic       same;

  // cnt==0 means no run yet, so the first bit always starts a fresh run
  assign same = (cnt != 8'd0) && (in_bit == last);
  // combinational so the sequencer can leave on the same edge as the tripping bit
  assign fail = en && valid && same && (cnt >= 8'(REP_LIMIT - 1));

  // run tracking, saturating at REP_LIMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 8'd0;
      last <= 1'b0;
    end else if (clr) begin
      cnt  <= 8'd0;
      last <= 1'b0;
    end else if (en && valid) begin
      last <= in_bit;
      if (!same)                      cnt <= 8'd1;
      else if (cnt != 8'(REP_LIMIT))  cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/trng_seq_ctrl.sv
// TRNG sequencer: chain enable, warm-up, bit packing, handshake and health gating.
module trng_seq_ctrl
  import trng_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int WARMUP_W  = 8,
  parameter int REP_LIMIT = REP_LIMIT_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [WARMUP_W-1:0] i_warmup_cycles,
  input  logic                i_random,
  input  logic                i_valid,
  output logic                o_en_chain,
  output logic [DATA_W-1:0]   o_data,
  output logic                o_data_valid,
  input  logic                i_data_ready,
  output logic                o_busy,
  output logic                o_health_fail
);

  localparam int BW = $clog2(DATA_W + 1);

  state_t              state, state_n;
  logic [WARMUP_W-1:0] wcnt;
  logic [BW-1:0]       bcnt;
  logic [DATA_W-1:0]   sh;
  logic                rep_fail;
  logic                xfer;
  logic                last_bit;

  assign xfer     = o_data_valid && i_data_ready;
  assign last_bit = i_valid && (bcnt == BW'(DATA_W - 1));
  assign o_busy   = (state != IDLE);

  trng_rep_test #(.REP_LIMIT(REP_LIMIT)) u_rep (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .clr    (state == WARMUP),
    .en     ((state == COLLECT) || (state == HOLD)),
    .in_bit (i_random),
    .valid  (i_valid),
    .fail   (rep_fail)
  );

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_n;
  end

  // next state and chain enable; stop beats health fail, health fail beats packing
  always_comb begin
    state_n    = state;
    o_en_chain = 1'b0;
    case (state)
      IDLE:    if (i_start && !i_stop) state_n = WARMUP;
      WARMUP: begin
        o_en_chain = 1'b1;
        if (i_stop)             state_n = IDLE;
        else if (wcnt == '0)    state_n = COLLECT;
      end
      COLLECT: begin
        o_en_chain = 1'b1;
        if (i_stop)             state_n = IDLE;
        else if (rep_fail)      state_n = FAIL;
        else if (last_bit)      state_n = HOLD;
      end
      HOLD: begin
        o_en_chain = 1'b1;
        if (i_stop)             state_n = IDLE;
        else if (rep_fail)      state_n = FAIL;
        else if (xfer)          state_n = COLLECT;
      end
      FAIL: begin
        if (i_stop)             state_n = IDLE;
        else if (i_start)       state_n = WARMUP;
      end
      default:                  state_n = IDLE;
    endcase
  end

  // warm-up counter: loaded on WARMUP entry, counts down to zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                 wcnt <= '0;
    else if (state_n == WARMUP && state != WARMUP) wcnt <= i_warmup_cycles;
    else if (state == WARMUP && wcnt != '0)       wcnt <= wcnt - 1'b1;
  end

  // LSB-first packing; partial words are dropped whenever COLLECT/HOLD is left
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh   <= '0;
      bcnt <= '0;
    end else if (state == COLLECT && i_valid &&
                 (state_n == COLLECT || state_n == HOLD)) begin
      sh   <= {i_random, sh[DATA_W-1:1]};
      bcnt <= last_bit ? '0 : bcnt + 1'b1;
    end else if (state_n != COLLECT && state_n != HOLD) begin
      bcnt <= '0;
    end
  end

  // output word, valid flag and sticky health flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data        <= '0;
      o_data_valid  <= 1'b0;
      o_health_fail <= 1'b0;
    end else begin
      if (state == COLLECT && state_n == HOLD)
        o_data <= {i_random, sh[DATA_W-1:1]};
      o_data_valid <= (state_n == HOLD);
      if (state_n == FAIL)
        o_health_fail <= 1'b1;
      else if (state == FAIL && state_n == WARMUP)
        o_health_fail <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trng_seq_ctrl.sv
// Directed bench for trng_seq_ctrl (DATA_W=8, REP_LIMIT=16).
module tb_trng_seq_ctrl;
  import trng_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, rnd, vld, ready;
  logic [7:0] warm;
  logic       en_chain, dvalid, busy, hfail;
  logic [7:0] data;
  int         total = 0, bad = 0, xfers = 0;

  trng_seq_ctrl #(.DATA_W(8), .WARMUP_W(8), .REP_LIMIT(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
    .i_warmup_cycles(warm), .i_random(rnd), .i_valid(vld),
    .o_en_chain(en_chain), .o_data(data), .o_data_valid(dvalid),
    .i_data_ready(ready), .o_busy(busy), .o_health_fail(hfail)
  );

  always #5 clk = ~clk;

  // count completed handshakes (sees pre-edge values)
  always @(posedge clk) if (dvalid && ready) xfers++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      vld = 1'b1; rnd = bits[i]; tick();
    end
    vld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; stop = 0; rnd = 0; vld = 0; ready = 0; warm = 0;
    #2;
    chk("reset_outs", {23'd0, en_chain, dvalid, busy, hfail, data}, 32'd0);
    chk("reset_state", dut.state, ST_IDLE);
    #10 rst_n = 1'b1;
    tick();

    // start with warm-up 3; valid bits during warm-up must be ignored
    warm = 8'd3; start = 1'b1; tick(); start = 1'b0;
    chk("warm_en", {en_chain, busy}, 2'b11);
    chk("warm_state", dut.state, ST_WARMUP);
    vld = 1'b1; rnd = 1'b1;
    tick(); tick(); tick();
    chk("warm_still", dut.state, ST_WARMUP);
    tick(); vld = 1'b0;
    chk("collect_entry", dut.state, ST_COLLECT);

    // word 1,0,1,1,0,0,1,0 LSB first -> 4D, held through back-pressure
    send(8'b0100_1101, 8);
    chk("word1_valid", dvalid, 1'b1);
    chk("word1_data", data, 8'h4D);
    for (int i = 0; i < 5; i++) tick();
    chk("word1_hold", {dvalid, data}, {1'b1, 8'h4D});
    ready = 1'b1; tick(); ready = 1'b0;
    chk("word1_taken", dvalid, 1'b0);
    chk("word1_state", dut.state, ST_COLLECT);
    chk("xfers_1", xfers, 1);

    // 16 ones trip the health test; the pending word is discarded
    send(8'hFF, 8);
    chk("rep_hold", dvalid, 1'b1);
    send(8'hFF, 7);
    chk("rep_15", hfail, 1'b0);
    send(8'hFF, 1);
    chk("rep_fail", {hfail, en_chain, dvalid, busy}, 4'b1001);
    chk("rep_state", dut.state, ST_FAIL);
    chk("rep_noxfer", xfers, 1);
    warm = 8'd0; start = 1'b1; tick(); start = 1'b0;
    chk("restart_clr", {hfail, en_chain}, 2'b01);
    chk("restart_state", dut.state, ST_WARMUP);
    tick();
    chk("warm0_collect", dut.state, ST_COLLECT);

    // stop after 5 bits, restart, new word holds only new bits
    send(8'b0001_0101, 5);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_idle", {en_chain, busy}, 2'b00);
    warm = 8'd1; start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("restart2", dut.state, ST_COLLECT);
    send(8'h96, 8);
    chk("word2", {dvalid, data}, {1'b1, 8'h96});

    // stop and ready together: transfer completes, then IDLE
    stop = 1'b1; ready = 1'b1; tick(); stop = 1'b0; ready = 1'b0;
    chk("stopxfer_state", dut.state, ST_IDLE);
    chk("stopxfer_out", {dvalid, busy}, 2'b00);
    chk("xfers_2", xfers, 2);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("start_stop", {busy, dut.state}, {1'b0, ST_IDLE});

    // async reset while a word is held
    warm = 8'd0; start = 1'b1; tick(); start = 1'b0; tick();
    send(8'h53, 8);
    chk("word3", {dvalid, data}, {1'b1, 8'h53});
    #2 rst_n = 1'b0; #1;
    chk("arst_hold", {23'd0, en_chain, dvalid, busy, hfail, data}, 32'd0);
    #1 rst_n = 1'b1; tick();

    // async reset clears a sticky health failure
    start = 1'b1; tick(); start = 1'b0; tick();
    ready = 1'b1; send(8'h00, 8); send(8'h00, 8); ready = 1'b0;
    chk("fail_zeros", hfail, 1'b1);
    #2 rst_n = 1'b0; #1;
    chk("arst_fail", {en_chain, dvalid, busy, hfail}, 4'b0000);
    #1 rst_n = 1'b1; tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
